instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writes a program into the processor's instruction memory from a byte stream, the write-side counterpart to the fetch-side memory read port. Receives a 16-bit word-count header and then 32-bit instructions as bytes over a valid/ready handshake. Assembles each big-endian instruction and drives a single-cycle memory write. Holds the processor in a stalled state until the whole program is committed.

## Interface
- DEPTH, 256: instruction memory depth in words; the legal header count is 1..DEPTH.
- WORD_WIDTH, 32: instruction width.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
- mem_we  out  1  one-cycle write strobe to the instruction memory.
- mem_addr  out  32  word address of the write, zero-extended from the word index.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  processor stall; high until a load completes.
- done  out  1  level signal: the program is fully committed.
- error  out  1  level signal: the header was illegal and the load was aborted.

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERROR.
- IDLE: rx_ready=0. start -> LEN_HI.
- LEN_HI: rx_ready=1. On transfer, count[15:8] <= byte, then -> LEN_LO.
- LEN_LO: rx_ready=1. On transfer, count[7:0] <= byte.
  - If the full count is 0 or greater than DEPTH -> ERROR.
  - Otherwise, word_idx<=0, byte_idx<=0, then -> DATA.
- DATA: rx_ready=1. Each transfer does shift <= {shift[23:0], byte} (MSB first) and byte_idx++ (2-bit, wraps).
  - On the transfer with byte_idx==3, register mem_we=1, mem_addr=word_idx, mem_wdata={shift[23:0], byte}.
  - If word_idx==count-1, go to FLUSH. Otherwise word_idx++.
- FLUSH: rx_ready=0, mem_we=0. Unconditionally -> DONE. This gives the last write one edge to commit before the processor is released.
- DONE: done=1, cpu_hold=0, rx_ready=0. start -> LEN_HI; done clears and cpu_hold rises on the same edge.
- ERROR: error=1, cpu_hold=1, rx_ready=0. start -> LEN_HI and error clears.
- start in LEN_HI, LEN_LO, DATA or FLUSH is ignored.
- Bytes offered while rx_ready=0 are not consumed.
- Memory words beyond count are not written. Old contents persist.

## Timing
- Reset values: state=IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0. Internal count, word_idx, byte_idx and shift are all 0.
- mem_we is registered and lasts exactly one cycle. It rises the cycle after the 4th byte's transfer edge.
- rx_ready stays high in DATA while mem_we pulses, so back-to-back words need no bubble. Minimum load time is 2+4N transfer cycles plus 2.
- done and the cpu_hold fall occur one cycle after the final mem_we pulse.
- Gaps in rx_valid stall the assembly only. Partial bytes are retained indefinitely.
- Reset asserted mid-load returns all registers to their reset values immediately, dropping any partial word. Memory contents already written are not cleared.
- count is 16 bits. Comparisons against DEPTH use 17-bit unsigned arithmetic. word_idx is log2(DEPTH) bits and never exceeds DEPTH-1.

## Structure
- Shared processor package gets:
  - the loader state enum;
  - LOADER_HDR_BYTES=2;
  - BYTES_PER_WORD=4;
  - INSTR_MEM_DEPTH=256, shared with the instruction memory so the two cannot diverge.
- Single module. The byte-to-word shifter is small enough to stay inline; no sub-module.
- mem_we, mem_addr and mem_wdata connect to a write port added to the instruction memory. Its combinational read port remains unchanged.

## Test plan
- Three-word load, stream 00 03 12 34 56 78 9A BC DE F0 00 00 00 01 with rx_valid held high:
  - writes 0x12345678@0, 0x9ABCDEF0@1 and 0x00000001@2, one mem_we pulse each;
  - done rises 1 cycle after the third pulse, and cpu_hold falls with it.
- Header 00 00 -> ERROR. error=1, cpu_hold=1, no mem_we, rx_ready=0. A subsequent start reaches LEN_HI with error=0.
- Headers 01 01 (257) -> ERROR. Header 01 00 (256) with 1024 data bytes -> the last write lands at address 255, then done.
- Random rx_valid gaps (about 50% duty) on the three-word stream -> identical writes and addresses. No byte is lost or duplicated.
- Reset pulsed after 6 of 14 bytes -> all outputs at reset values. After start and the full stream, the correct three writes occur.
- start pulsed in DATA -> ignored and the load completes normally. Bytes offered in DONE are not accepted (rx_ready=0).

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared processor definitions for the instruction-memory loader.
// INSTR_MEM_DEPTH is also used by the instruction memory so the two sizes always agree.
package instruction_loader_pkg;

    localparam int LOADER_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD   = 4;
    localparam int INSTR_MEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_FLUSH,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// Streams a length-prefixed program into instruction memory over a byte handshake,
// assembling big-endian words and stalling the processor until the load commits.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH      = INSTR_MEM_DEPTH,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int AW = $clog2(DEPTH);

    loader_state_t         state;
    logic [15:0]           count;
    logic [AW-1:0]         word_idx;
    logic [1:0]            byte_idx;
    logic [WORD_WIDTH-9:0] shift;

    logic                  transfer;
    logic [15:0]           hdr_count;
    logic                  hdr_bad;
    logic                  last_word;
    logic                  last_byte;
    logic [WORD_WIDTH-1:0] assembled;

    assign transfer  = rx_valid && rx_ready;
    assign hdr_count = {count[15:8], rx_data};
    // Widen to 17 bits so a count of 65535 cannot wrap past DEPTH.
    assign hdr_bad   = (hdr_count == 16'd0) || ({1'b0, hdr_count} > 17'(DEPTH));
    assign last_word = (16'(word_idx) == count - 16'd1);
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign assembled = {shift, rx_data};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= LD_IDLE;
            count     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        state    <= LD_LEN_HI;
                        rx_ready <= 1'b1;
                    end
                end
                LD_LEN_HI: begin
                    if (transfer) begin
                        count[15:8] <= rx_data;
                        state       <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (transfer) begin
                        count <= hdr_count;
                        if (hdr_bad) begin
                            state    <= LD_ERROR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (transfer) begin
                        shift    <= assembled[WORD_WIDTH-9:0];
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= 32'(word_idx);
                            mem_wdata <= assembled;
                            if (last_word) begin
                                state    <= LD_FLUSH;
                                rx_ready <= 1'b0;
                            end else begin
                                word_idx <= word_idx + AW'(1);
                            end
                        end
                    end
                end
                // One idle edge lets the final write settle before the processor runs.
                LD_FLUSH: begin
                    state    <= LD_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                LD_DONE: begin
                    if (start) begin
                        state    <= LD_LEN_HI;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                        rx_ready <= 1'b1;
                    end
                end
                LD_ERROR: begin
                    if (start) begin
                        state    <= LD_LEN_HI;
                        error    <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= LD_IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Table-driven bench for instruction_loader with a write scoreboard checked on the memory port.
module tb_instruction_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    instruction_loader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] hdr;
        int          nwords;
        bit          exp_err;
        bit          canon;
        bit          gaps;
    } vec_t;

    wr_t         sb[$];
    vec_t        vecs[6];
    logic [31:0] canon_w[3];
    int          checks;
    int          errors;
    int          cycle;
    int          writes;
    int          last_we_cycle;
    int          done_rise_cycle;
    logic        done_q;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clock);
            cycle++;
            if (mem_we) begin
                writes++;
                last_we_cycle = cycle;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    checkOutput("write_addr", mem_addr, e.addr);
                    checkOutput("write_data", mem_wdata, e.data);
                end
            end
            if (done && !done_q) done_rise_cycle = cycle;
            done_q = done;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_accept_timeout: got rx_ready 0 expected 1");
        end
        @(negedge clock);
    endtask

    task automatic sendWord(input int idx, input logic [31:0] w, input bit gaps);
        wr_t e;
        e.addr = 32'(idx);
        e.data = w;
        sb.push_back(e);
        for (int k = 3; k >= 0; k--) applyStimulus(w[k*8 +: 8], gaps);
    endtask

    task automatic waitEnd(input bit exp_err, input int nwords);
        int guard;
        guard = 0;
        while (!(done || error) && guard < 3000) begin
            @(negedge clock);
            #1;
            guard++;
        end
        rx_valid = 1'b0;
        checkOutput("end_reached", 32'(guard < 3000), 32'd1);
        checkOutput("error_flag", 32'(error), 32'(exp_err));
        checkOutput("done_flag", 32'(done), 32'(!exp_err));
        checkOutput("cpu_hold", 32'(cpu_hold), 32'(exp_err));
        checkOutput("rx_ready_end", 32'(rx_ready), 32'd0);
        checkOutput("write_count", 32'(writes), 32'(nwords));
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        if (!exp_err) checkOutput("done_latency", 32'(done_rise_cycle - last_we_cycle), 32'd1);
    endtask

    task automatic checkReset();
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
    endtask

    task automatic startLoad(input logic [15:0] hdr, input bit gaps);
        writes = 0;
        pulseStart();
        checkOutput("start_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("start_error_clr", 32'(error), 32'd0);
        checkOutput("start_cpu_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(hdr[15:8], gaps);
        applyStimulus(hdr[7:0], gaps);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle = 0;
        writes = 0;
        last_we_cycle = 0;
        done_rise_cycle = 0;
        done_q = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        canon_w[0] = 32'h12345678;
        canon_w[1] = 32'h9ABCDEF0;
        canon_w[2] = 32'h00000001;
        vecs[0] = '{hdr: 16'h0003, nwords: 3,   exp_err: 1'b0, canon: 1'b1, gaps: 1'b0};
        vecs[1] = '{hdr: 16'h0000, nwords: 0,   exp_err: 1'b1, canon: 1'b0, gaps: 1'b0};
        vecs[2] = '{hdr: 16'h0101, nwords: 0,   exp_err: 1'b1, canon: 1'b0, gaps: 1'b0};
        vecs[3] = '{hdr: 16'h0100, nwords: 256, exp_err: 1'b0, canon: 1'b0, gaps: 1'b0};
        vecs[4] = '{hdr: 16'h0003, nwords: 3,   exp_err: 1'b0, canon: 1'b1, gaps: 1'b1};
        vecs[5] = '{hdr: 16'h0001, nwords: 1,   exp_err: 1'b0, canon: 1'b0, gaps: 1'b1};

        fork
            monitor();
        join_none

        repeat (3) @(negedge clock);
        checkReset();
        reset = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d header %h", v, vecs[v].hdr);
            startLoad(vecs[v].hdr, vecs[v].gaps);
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < vecs[v].nwords; i++)
                    sendWord(i, (vecs[v].canon && i < 3) ? canon_w[i] : $urandom, vecs[v].gaps);
            end
            waitEnd(vecs[v].exp_err, vecs[v].nwords);
        end

        $display("[TB] bytes offered in DONE");
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        repeat (4) begin
            @(negedge clock);
            checkOutput("done_rx_ready", 32'(rx_ready), 32'd0);
        end
        checkOutput("done_hold", 32'(done), 32'd1);
        rx_valid = 1'b0;

        $display("[TB] start pulsed in DATA");
        startLoad(16'h0003, 1'b0);
        sendWord(0, canon_w[0], 1'b0);
        start = 1'b1;
        applyStimulus(8'h9A, 1'b0);
        start = 1'b0;
        sb.push_back('{addr: 32'd1, data: canon_w[1]});
        applyStimulus(8'hBC, 1'b0);
        applyStimulus(8'hDE, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        sendWord(2, canon_w[2], 1'b0);
        waitEnd(1'b0, 3);

        $display("[TB] reset mid-load");
        startLoad(16'h0003, 1'b0);
        sendWord(0, canon_w[0], 1'b0);
        rx_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkReset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        startLoad(16'h0003, 1'b0);
        for (int i = 0; i < 3; i++) sendWord(i, canon_w[i], 1'b0);
        waitEnd(1'b0, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
